ro_scan_sequencer: RTL and testbench

Controller for the ring-oscillator measurement array. It enables exactly one RO at a time and lets it settle. It then gates the RO-domain edge counter for a fixed window, waits for the synchronised count, and hands an {index, count} record to the UART framer over a valid/ready handshake. It replaces the free-running seconds-based RO selection with a deterministic, back-pressured scan.

---
 rtl/ro_scan_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ro_scan_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_scan_sequencer.sv
// ro_scan_sequencer: deterministic, back-pressured ring-oscillator scan.
// For each RO in turn it enables it, waits for it to settle, gates the
// RO-domain edge counter for a fixed window, waits for the synchronised
// count and hands an {index, count} record to the UART framer.
// Optional feature macro: RO_SCAN_LOOP_EN (continuous scanning until abort).
module ro_scan_sequencer #(
  parameter int unsigned NUM_RO        = 150,
  parameter int unsigned IDX_W         = 8,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned WINDOW_CYCLES = 100000,
  parameter int unsigned SYNC_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_RO-1:0] ro_en,
  output logic              cnt_clr,
  output logic              cnt_gate,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_data,
  output logic              busy,
  output logic              scan_done
);

  // One shared timer covers settle, window and sync; size it for the longest.
  localparam int unsigned T_MAX_SW = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int unsigned T_MAX    = (T_MAX_SW > SYNC_CYCLES) ? T_MAX_SW : SYNC_CYCLES;
  localparam int unsigned TMR_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] SYNC_LOAD   = TMR_W'(SYNC_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_RO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SETTLE,
    S_GATE,
    S_SYNC,
    S_OUTPUT
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [NUM_RO-1:0]  ro_en_d;
  logic [NUM_RO-1:0]  sel;
  logic               cnt_clr_d, cnt_gate_d, res_valid_d, busy_d, scan_done_d;
  logic [IDX_W-1:0]   res_idx_d;
  logic [CNT_W-1:0]   res_data_d;

  // One-hot decode of the current index, used when an RO is switched on.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
  end

  // Next-state and next-output logic; abort overrides every state and start.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    timer_d     = timer;
    ro_en_d     = ro_en;
    cnt_clr_d   = 1'b0;
    cnt_gate_d  = cnt_gate;
    res_valid_d = res_valid;
    res_idx_d   = res_idx;
    res_data_d  = res_data;
    busy_d      = busy;
    scan_done_d = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      timer_d     = '0;
      ro_en_d     = '0;
      cnt_gate_d  = 1'b0;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_ENABLE;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
        S_ENABLE: begin
          ro_en_d   = sel;
          cnt_clr_d = 1'b1;
          timer_d   = SETTLE_LOAD;
          state_d   = S_SETTLE;
        end
        S_SETTLE: begin
          if (timer == '0) begin
            cnt_gate_d = 1'b1;
            timer_d    = WINDOW_LOAD;
            state_d    = S_GATE;
          end else begin
            timer_d = timer - TMR_W'(1);
          end
        end
        S_GATE: begin
          if (timer == '0) begin
            cnt_gate_d = 1'b0;
            timer_d    = SYNC_LOAD;
            state_d    = S_SYNC;
          end else begin
            timer_d = timer - TMR_W'(1);
          end
        end
        S_SYNC: begin
          if (timer == '0) begin
            res_data_d  = cnt_value;
            res_idx_d   = idx;
            ro_en_d     = '0;
            res_valid_d = 1'b1;
            state_d     = S_OUTPUT;
          end else begin
            timer_d = timer - TMR_W'(1);
          end
        end
        S_OUTPUT: begin
          if (res_valid && res_ready) begin
            res_valid_d = 1'b0;
            if (idx == LAST_IDX) begin
              scan_done_d = 1'b1;
              idx_d       = '0;
`ifdef RO_SCAN_LOOP_EN
              state_d     = S_ENABLE;
`else
              state_d     = S_IDLE;
              busy_d      = 1'b0;
`endif
            end else begin
              idx_d   = idx + IDX_W'(1);
              state_d = S_ENABLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, timer and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      ro_en     <= '0;
      cnt_clr   <= 1'b0;
      cnt_gate  <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      timer     <= timer_d;
      ro_en     <= ro_en_d;
      cnt_clr   <= cnt_clr_d;
      cnt_gate  <= cnt_gate_d;
      res_valid <= res_valid_d;
      res_idx   <= res_idx_d;
      res_data  <= res_data_d;
      busy      <= busy_d;
      scan_done <= scan_done_d;
    end
  end

endmodule

// File: tb/tb_ro_scan_sequencer.sv
// Testbench for ro_scan_sequencer: random back-pressure and per-RO counter
// rates, checked against timing/record rules kept in the bench.
module tb_ro_scan_sequencer;
  localparam int unsigned N = 4;
  localparam int unsigned S = 3;
  localparam int unsigned W = 10;
  localparam int unsigned Y = 2;
`ifdef RO_SCAN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n, start, abort, res_ready;
  logic [N-1:0]  ro_en;
  logic          cnt_clr, cnt_gate, res_valid, busy, scan_done;
  logic [31:0]   cnt_value, res_data;
  logic [7:0]    res_idx;

  always #5 clk = ~clk;

  ro_scan_sequencer #(
    .NUM_RO(N), .IDX_W(8), .CNT_W(32),
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .SYNC_CYCLES(Y)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .ro_en(ro_en), .cnt_clr(cnt_clr), .cnt_gate(cnt_gate),
    .cnt_value(cnt_value), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_data(res_data), .busy(busy), .scan_done(scan_done)
  );

  // Edge-counter model: each RO adds its rate per gated cycle; the result is
  // only presented after the synchroniser delay, noise before that.
  int unsigned rate [N];
  logic [31:0] acc = '0;
  logic [31:0] noise = '0;
  int unsigned since_fall = 255;

  function automatic logic [31:0] gate_rate(input logic [N-1:0] en);
    logic [31:0] r;
    r = 32'h5A5A;
    for (int i = 0; i < int'(N); i++) if (en == (N'(1) << i)) r = rate[i];
    return r;
  endfunction

  always @(negedge clk) begin
    noise <= $urandom();
    if (cnt_clr) acc <= '0;
    else if (cnt_gate) acc <= acc + gate_rate(ro_en);
    if (cnt_gate) since_fall <= 0;
    else if (since_fall < 255) since_fall <= since_fall + 1;
  end
  assign cnt_value = (since_fall >= Y) ? acc : noise;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int unsigned i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference state: expected next index, the RO in use, event timestamps.
  int          cyc = 0;
  int unsigned nxt = 0, cur = 0;
  int          en_cyc = 0, fall_cyc = -100, acc_cyc = 0, gfall_cyc = 0, glen = 0;
  bit          after_acc = 1'b0;
  logic        p_valid = 1'b0, p_busy = 1'b0, p_gate = 1'b0;
  logic [N-1:0] p_ro = '0;
  int unsigned recs[$];
  int unsigned hold = 0;

  task automatic monitor();
    logic accept, start_idle;
    cyc++;
    if (!reset_n) begin
      nxt = 0; after_acc = 1'b0; glen = 0; fall_cyc = cyc;
      p_valid = 1'b0; p_busy = 1'b0; p_gate = 1'b0; p_ro = '0;
      return;
    end
    accept     = p_valid && res_ready && !abort;
    start_idle = !p_busy && start && !abort;
    chk("onehot", 64'($countones(ro_en) <= 1), 64'd1);
    chk("scan_done", 64'(scan_done), 64'(accept && cur == N - 1));
    if (abort) begin
      chk("abort_ro_en", 64'(ro_en), 64'd0);
      chk("abort_gate", 64'(cnt_gate), 64'd0);
      chk("abort_valid", 64'(res_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      nxt = 0; after_acc = 1'b0;
    end
    if (accept) begin
      chk("valid_drop", 64'(res_valid), 64'd0);
      if (cur == N - 1) chk("busy_after_last", 64'(busy), 64'(LOOP));
      recs.push_back(cur);
      nxt = (cur + 1) % N;
      after_acc = 1'b1;
      acc_cyc = cyc;
    end
    if (start_idle) begin
      chk("busy_on_start", 64'(busy), 64'd1);
      nxt = 0; after_acc = 1'b0;
    end
    if (p_ro == '0 && ro_en != '0) begin
      chk("en_idx", 64'(ro_en), 64'(onehot(nxt)));
      chk("en_gap", 64'(cyc - fall_cyc >= 2), 64'd1);
      if (after_acc) chk("en_after_accept", 64'(cyc - acc_cyc), 64'd1);
      after_acc = 1'b0;
      en_cyc = cyc;
      cur = nxt;
    end
    if (p_ro != '0 && ro_en == '0) fall_cyc = cyc;
    if (!p_gate && cnt_gate) begin
      chk("settle_len", 64'(cyc - en_cyc), 64'(S));
      chk("gate_ro", 64'(ro_en), 64'(onehot(cur)));
      glen = 1;
    end else if (p_gate && cnt_gate) begin
      glen++;
    end else if (p_gate && !cnt_gate && !abort) begin
      chk("window_len", 64'(glen), 64'(W));
      gfall_cyc = cyc;
    end
    if (!p_valid && res_valid) begin
      chk("sync_len", 64'(cyc - gfall_cyc), 64'(Y));
      chk("res_idx", 64'(res_idx), 64'(cur));
      chk("res_data", 64'(res_data), 64'(W * rate[cur]));
      chk("ro_off_out", 64'(ro_en), 64'd0);
    end
    if (p_valid && res_valid) begin
      chk("hold_idx", 64'(res_idx), 64'(cur));
      chk("hold_data", 64'(res_data), 64'(W * rate[cur]));
      chk("hold_ro_off", 64'(ro_en), 64'd0);
      chk("hold_gate_off", 64'(cnt_gate), 64'd0);
    end
    p_valid = res_valid; p_busy = busy; p_gate = cnt_gate; p_ro = ro_en;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic new_rates();
    for (int i = 0; i < int'(N); i++) rate[i] = $urandom_range(1, 1000);
  endtask

  // mode 0: always ready; mode 1: random ready, 50-cycle stall on record 1,
  // random start pulses while busy.
  task automatic drive(input int mode);
    if (mode == 0) begin
      res_ready = 1'b1;
    end else begin
      if (res_valid && res_idx == 8'd1 && hold < 50) begin
        res_ready = 1'b0;
        hold++;
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
      start = busy && ($urandom_range(0, 5) == 0);
    end
  endtask

  task automatic run_scan(input int mode);
    int need, done;
    need = LOOP ? 2 : 1;
    done = 0;
    hold = 0;
    recs.delete();
    drive(mode);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3000 && done < need; c++) begin
      drive(mode);
      step();
      if (scan_done) done++;
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk("scan_finished", 64'(done), 64'(need));
    if (LOOP) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
    end
    step();
    chk("idle_after_scan", 64'(busy), 64'd0);
    chk("rec_count", 64'(recs.size()), 64'(N * need));
    for (int i = 0; i < recs.size(); i++) chk("rec_order", 64'(recs[i]), 64'(i % N));
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    new_rates();
    repeat (3) step();
    chk("rst_ro_en", 64'(ro_en), 64'd0);
    chk("rst_clr", 64'(cnt_clr), 64'd0);
    chk("rst_gate", 64'(cnt_gate), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_idx", 64'(res_idx), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(scan_done), 64'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // Full scan with the framer always ready.
    run_scan(0);

    // Random back-pressure, long stall on record 1, start pulses while busy.
    new_rates();
    run_scan(1);

    // Abort during the gate window of RO 2, then restart from index 0.
    new_rates();
    res_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (cnt_gate && ro_en == onehot(2)) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_target_reached", 64'(found), 64'd1);
    repeat ($urandom_range(0, 4)) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (5) step();
    chk("abort_stays_idle", 64'(busy), 64'd0);
    run_scan(0);

    // Asynchronous reset while an RO is settling.
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ro_en != '0 && !cnt_gate) begin
        found = 1'b1;
        break;
      end
    end
    chk("settle_reached", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_ro_en", 64'(ro_en), 64'd0);
    chk("async_clr", 64'(cnt_clr), 64'd0);
    chk("async_gate", 64'(cnt_gate), 64'd0);
    chk("async_valid", 64'(res_valid), 64'd0);
    chk("async_idx", 64'(res_idx), 64'd0);
    chk("async_data", 64'(res_data), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(scan_done), 64'd0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // start and abort together: abort wins, block stays idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) step();
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_ro_en", 64'(ro_en), 64'd0);

    // Final randomised scan after all the disturbances.
    new_rates();
    run_scan(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
